alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance between NUM_REQ requesters, e.g. the execute stage, the branch-target adder path and the address-generation path of the RV32 core.
- Each requester issues an operation over a valid/ready request channel and receives its result on a valid/ready response channel.
- Arbitration is round-robin. One operation is in flight at a time.
- The block registers the operands into the ALU, captures the ALU result, and holds it until the owning requester accepts it.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of the internal owner index; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester request ready; one-hot or zero.
- req_operand_1_i  in  NUM_REQ x 32  first operand per requester.
- req_operand_2_i  in  NUM_REQ x 32  second operand per requester.
- req_funct7_i  in  NUM_REQ x alu_funct7_e  operand-2 modifier (NEG or pass).
- req_funct3_i  in  NUM_REQ x alu_funct3_e  operation select (ADD, AND, others).
- rsp_valid_o  out  NUM_REQ  per-requester response valid; one-hot or zero.
- rsp_ready_i  in  NUM_REQ  per-requester response ready.
- rsp_result_o  out  32  result; meaningful only while some rsp_valid_o bit is set.
- alu_operand_1_o  out  32  to shared ALU.
- alu_operand_2_o  out  32  to shared ALU.
- alu_funct7_o  out  alu_funct7_e  to shared ALU.
- alu_funct3_o  out  alu_funct3_e  to shared ALU.
- alu_result_i  in  32  from shared ALU; combinational.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:

Reset (async on rst_i high; takes effect immediately):
- state=IDLE, rr_ptr=0, owner=0.
- Operand registers=0, funct3 register=ADD, funct7 register=all-zero encoding, result_q=0.
- All outputs are therefore 0 / ADD / zero encoding, and req_ready_o=0, rsp_valid_o=0, busy_o=0.

Reset mid-operation:
- The in-flight op is discarded. No response is ever issued for it.
- The requester must re-issue after reset.

FSM states: IDLE, EXEC, RESP.

IDLE:
- grant = first requester with req_valid_i set, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
- req_ready_o = one-hot(grant) combinationally; all zero if no request is valid.
- On handshake (req_valid_i[g] && req_ready_o[g]): latch operands, funct7, funct3 and owner=g; go to EXEC.
- req_ready_o must not depend on rsp_ready_i.

EXEC:
- alu_*_o are driven from the latched registers in every state, so the ALU sees the op this cycle.
- result_q <= alu_result_i.
- rr_ptr <= (owner+1) mod NUM_REQ.
- Go to RESP.
- req_ready_o=0.

RESP:
- rsp_valid_o[owner]=1 and rsp_result_o=result_q. Both are stable until accepted.
- On rsp_ready_i[owner]: go to IDLE.
- rsp_ready_i bits of non-owners are ignored.
- No new grant in the same cycle the response is accepted.
- rsp_result_o=0 whenever state is not RESP.

Timing:
- Latency: request handshake in cycle N, rsp_valid_o high from cycle N+2.
- Minimum issue interval is 3 cycles.

Request-side rules:
- Requests not granted simply wait; the block never drops them.
- A requester may deassert valid before grant without penalty.
- A requester whose valid is held high is granted within NUM_REQ operations (fairness).
- Operands of a granted request may change after the handshake; the latched copies are used.

Arithmetic:
- Performed entirely by the external ALU: 32-bit, wrap-around modulo 2^32, no flags.
- The block passes funct7/funct3 through unmodified.
- Unsupported funct3 values yield whatever the ALU returns (0).

Test Plan:
1. Single op: req0 issues ADD, 5 and 7, at cycle N -> rsp_valid_o=2'b01 at N+2, rsp_result_o=12, busy_o high N+1..until accept.
2. NEG/AND: req1 issues NEG+ADD, 5 and 3 -> result 2. Then req1 issues AND, 0xF0F0_F0F0 and 0xFF00_FF00 -> result 0xF000_F000.
3. Contention after reset: req0 and req1 valid in the same cycle -> req0 granted first, req1 granted in the first IDLE after req0's response is accepted; the two results route to the correct rsp_valid_o bits.
4. Fairness: req0 valid continuously, req1 raises valid during req0's op -> the next grant is req1, then req0; strict alternation continues while both stay valid.
5. Back-pressure: rsp_ready_i held low 4 cycles in RESP -> rsp_valid_o and rsp_result_o stable, req_ready_o=0 throughout; accept returns to IDLE next cycle.
6. Reset mid-EXEC: assert rst_i during EXEC -> outputs clear immediately, no rsp_valid_o pulse afterwards, rr_ptr back to 0, so req0 wins the next contention.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// One op in flight: operands registered in, result captured and held until accepted.
package alu_share_pkg;
  typedef enum logic [6:0] {
    F7_PASS = 7'b0000000,
    F7_NEG  = 7'b0100000
  } alu_funct7_e;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SRL  = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } alu_funct3_e;
endpackage

module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_REQ-1:0]  req_valid_i,
  output logic [NUM_REQ-1:0]  req_ready_o,
  input  logic [31:0]         req_operand_1_i [NUM_REQ],
  input  logic [31:0]         req_operand_2_i [NUM_REQ],
  input  alu_funct7_e         req_funct7_i    [NUM_REQ],
  input  alu_funct3_e         req_funct3_i    [NUM_REQ],
  output logic [NUM_REQ-1:0]  rsp_valid_o,
  input  logic [NUM_REQ-1:0]  rsp_ready_i,
  output logic [31:0]         rsp_result_o,
  output logic [31:0]         alu_operand_1_o,
  output logic [31:0]         alu_operand_2_o,
  output alu_funct7_e         alu_funct7_o,
  output alu_funct3_e         alu_funct3_o,
  input  logic [31:0]         alu_result_i,
  output logic                busy_o
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  owner_q;
  logic [ID_W-1:0]  next_ptr;
  logic [31:0]      op1_q, op2_q;
  alu_funct7_e      f7_q;
  alu_funct3_e      f3_q;
  logic [31:0]      result_q;

  logic             grant_vld;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand;
  logic             take;

  // Scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Gating with rst_i keeps ready low while reset is held, even with requests pending.
  assign take     = (state_q == IDLE) && grant_vld && !rst_i;
  assign next_ptr = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready_i[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      f7_q     <= F7_PASS;
      f3_q     <= F3_ADD;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (take) begin
            owner_q <= grant_idx;
            op1_q   <= req_operand_1_i[grant_idx];
            op2_q   <= req_operand_2_i[grant_idx];
            f7_q    <= req_funct7_i[grant_idx];
            f3_q    <= req_funct3_i[grant_idx];
          end
        end
        EXEC: begin
          result_q <= alu_result_i;
          rr_ptr_q <= next_ptr;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (take) req_ready_o[grant_idx] = 1'b1;
    if (state_q == RESP) rsp_valid_o[owner_q] = 1'b1;
  end

  assign rsp_result_o    = (state_q == RESP) ? result_q : 32'd0;
  assign alu_operand_1_o = op1_q;
  assign alu_operand_2_o = op2_q;
  assign alu_funct7_o    = f7_q;
  assign alu_funct3_o    = f3_q;
  assign busy_o          = (state_q != IDLE);

endmodule
